// File: rtl/controlador_display.sv
// rtl/controlador_display.sv - multiplexed 4-digit display driver for corrector results
module controlador_display #(
  parameter int REFRESCO = 50000,
  parameter int PARPADEO = 12500000
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic       carga,
  input  logic [3:0] corregido,
  input  logic [2:0] sindrome,
  input  logic       error_simple,
  input  logic       error_doble,
  output logic [3:0] anodos,
  output logic [6:0] segmentos,
  output logic       led_simple,
  output logic       led_doble
);

  localparam int W_REF = (REFRESCO > 2) ? $clog2(REFRESCO) : 1;
  localparam int W_PAR = (PARPADEO > 2) ? $clog2(PARPADEO) : 1;
  localparam logic [W_REF-1:0] REF_MAX = W_REF'(REFRESCO - 1);
  localparam logic [W_PAR-1:0] PAR_MAX = W_PAR'(PARPADEO - 1);

  localparam logic [1:0] COD_NINGUNO = 2'd0;
  localparam logic [1:0] COD_SIMPLE  = 2'd1;
  localparam logic [1:0] COD_DOBLE   = 2'd2;

  logic [3:0]       dato_reg;
  logic [2:0]       sind_reg;
  logic [1:0]       codigo;
  logic [3:0]       cont_err;
  logic [W_REF-1:0] cnt_ref;
  logic [1:0]       indice;
  logic [W_PAR-1:0] cnt_par;
  logic             fase;
  logic [1:0]       codigo_nuevo;
  logic [3:0]       valor;
  logic             apagar;

  function automatic logic [6:0] hex_a_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_a_seg = 7'b1000000;
      4'h1: hex_a_seg = 7'b1111001;
      4'h2: hex_a_seg = 7'b0100100;
      4'h3: hex_a_seg = 7'b0110000;
      4'h4: hex_a_seg = 7'b0011001;
      4'h5: hex_a_seg = 7'b0010010;
      4'h6: hex_a_seg = 7'b0000010;
      4'h7: hex_a_seg = 7'b1111000;
      4'h8: hex_a_seg = 7'b0000000;
      4'h9: hex_a_seg = 7'b0010000;
      4'hA: hex_a_seg = 7'b0001000;
      4'hB: hex_a_seg = 7'b0000011;
      4'hC: hex_a_seg = 7'b1000110;
      4'hD: hex_a_seg = 7'b0100001;
      4'hE: hex_a_seg = 7'b0000110;
      default: hex_a_seg = 7'b0001110;
    endcase
  endfunction

  // Double error dominates when both flags are raised together
  always_comb begin
    codigo_nuevo = COD_NINGUNO;
    if (error_doble)
      codigo_nuevo = COD_DOBLE;
    else if (error_simple)
      codigo_nuevo = COD_SIMPLE;
  end

  // Latch corrector results on carga and count erroneous words, saturating at F
  always_ff @(posedge reloj) begin
    if (reset) begin
      dato_reg <= 4'h0;
      sind_reg <= 3'h0;
      codigo   <= COD_NINGUNO;
      cont_err <= 4'h0;
    end else if (carga) begin
      dato_reg <= corregido;
      sind_reg <= sindrome;
      codigo   <= codigo_nuevo;
      if (codigo_nuevo != COD_NINGUNO && cont_err != 4'hF)
        cont_err <= cont_err + 4'h1;
    end
  end

  // Refresh timer: hold each digit REFRESCO cycles, then advance to the next one
  always_ff @(posedge reloj) begin
    if (reset) begin
      cnt_ref <= '0;
      indice  <= 2'd0;
    end else if (cnt_ref == REF_MAX) begin
      cnt_ref <= '0;
      indice  <= indice + 2'd1;
    end else begin
      cnt_ref <= cnt_ref + 1'b1;
    end
  end

  // Free-running blink timer; phase flips every PARPADEO cycles
  always_ff @(posedge reloj) begin
    if (reset) begin
      cnt_par <= '0;
      fase    <= 1'b0;
    end else if (cnt_par == PAR_MAX) begin
      cnt_par <= '0;
      fase    <= ~fase;
    end else begin
      cnt_par <= cnt_par + 1'b1;
    end
  end

  // Select the nibble for the current digit and decide whether it is blanked
  always_comb begin
    valor = 4'h0;
    case (indice)
      2'd0:    valor = dato_reg;
      2'd1:    valor = {1'b0, sind_reg};
      2'd2:    valor = {2'b00, codigo};
      default: valor = cont_err;
    endcase
    apagar = (codigo == COD_DOBLE) && !fase && !indice[1];
  end

  // Register the display drive so anodes and segments change together
  always_ff @(posedge reloj) begin
    if (reset || apagar) begin
      anodos    <= 4'b1111;
      segmentos <= 7'b1111111;
    end else begin
      anodos    <= ~(4'b0001 << indice);
      segmentos <= hex_a_seg(valor);
    end
  end

  assign led_simple = !reset && (codigo == COD_SIMPLE);
  assign led_doble  = !reset && (codigo == COD_DOBLE) && fase;

endmodule

// File: tb/tb_controlador_display.sv
// tb/tb_controlador_display.sv - randomized bench with behavioural display model
module tb_controlador_display;

  localparam int R = 4;
  localparam int P = 8;

  logic       reloj = 1'b0;
  logic       reset = 1'b1;
  logic       carga = 1'b0;
  logic [3:0] corregido = 4'h0;
  logic [2:0] sindrome = 3'h0;
  logic       error_simple = 1'b0;
  logic       error_doble = 1'b0;
  logic [3:0] anodos;
  logic [6:0] segmentos;
  logic       led_simple;
  logic       led_doble;

  controlador_display #(.REFRESCO(R), .PARPADEO(P)) dut (
    .reloj(reloj),
    .reset(reset),
    .carga(carga),
    .corregido(corregido),
    .sindrome(sindrome),
    .error_simple(error_simple),
    .error_doble(error_doble),
    .anodos(anodos),
    .segmentos(segmentos),
    .led_simple(led_simple),
    .led_doble(led_doble)
  );

  always #5 reloj = ~reloj;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int checks = 0;
  int passed = 0;

  // Reference state: what has been latched, and how many cycles since reset
  int m_dato = 0;
  int m_sind = 0;
  int m_cod  = 0;
  int m_cnt  = 0;
  int m_t    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp)
      passed++;
    else
      $display("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
  endtask

  task automatic step(input logic r, input logic c, input logic [3:0] co,
                      input logic [2:0] s, input logic es, input logic ed);
    int idx;
    int ph;
    int val;
    int code;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    reset = r; carga = c; corregido = co; sindrome = s;
    error_simple = es; error_doble = ed;
    // Output after this edge shows what the model holds before it
    idx = (m_t / R) % 4;
    ph  = (m_t / P) % 2;
    case (idx)
      0: val = m_dato;
      1: val = m_sind;
      2: val = m_cod;
      default: val = m_cnt;
    endcase
    if (r || (m_cod == 2 && ph == 0 && idx < 2)) begin
      e_an = 4'b1111;
      e_seg = 7'b1111111;
    end else begin
      e_an = 4'b1111 ^ (4'b0001 << idx);
      e_seg = seg_tab[val];
    end
    @(posedge reloj);
    if (r) begin
      m_dato = 0; m_sind = 0; m_cod = 0; m_cnt = 0; m_t = 0;
    end else begin
      m_t++;
      if (c) begin
        code = ed ? 2 : (es ? 1 : 0);
        m_dato = co;
        m_sind = s;
        m_cod = code;
        if (code != 0 && m_cnt < 15) m_cnt++;
      end
    end
    #1;
    check("anodos", anodos, e_an);
    check("segmentos", segmentos, e_seg);
    check("led_simple", led_simple, !r && m_cod == 1);
    check("led_doble", led_doble, !r && m_cod == 2 && ((m_t / P) % 2 == 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
    idle(1);
    check("first_an", anodos, 4'b1110);
    check("first_seg", segmentos, 7'b1000000);
    idle(20);
    step(1'b0, 1'b1, 4'b1010, 3'b000, 1'b0, 1'b0);
    idle(20);
    step(1'b0, 1'b1, 4'b0010, 3'b101, 1'b1, 1'b0);
    idle(20);
    step(1'b0, 1'b1, 4'h7, 3'b011, 1'b0, 1'b1);
    idle(40);
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b1, 4'($urandom), 3'($urandom), 1'($urandom), 1'b1);
      idle(3);
    end
    step(1'b0, 1'b1, 4'h3, 3'h1, 1'b1, 1'b0);
    idle(20);
    check("cnt_sat_model", m_cnt, 15);
    step(1'b0, 1'b1, 4'h9, 3'h2, 1'b0, 1'b1);
    idle(5);
    step(1'b1, 1'b1, 4'h5, 3'h5, 1'b1, 1'b1);
    idle(1);
    check("rst_rel_an", anodos, 4'b1110);
    check("rst_rel_seg", segmentos, 7'b1000000);
    idle(20);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0)
        step(1'b1, 1'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      else
        step(1'b0, $urandom_range(0, 5) == 0, 4'($urandom), 3'($urandom),
             1'($urandom), $urandom_range(0, 3) == 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
